// File: rtl/spi_master_core_pkg.sv
// Shared types for the SPI master core: FSM state encoding and counter width.
package spi_master_core_pkg;

    // Frame sequencer states; encodings 6 and 7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PRE  = 3'd2,
        ST_TXRX = 3'd3,
        ST_POST = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Bit counter width; wide enough for the largest supported word (255 bits).
    localparam int BIT_CNT_W = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// Free-running SCLK divider: internal SCLK level plus one-cycle rise/fall strobes.
module spi_sclk_gen #(
    parameter int SCLK_DIV = 8
) (
    input  logic c,
    input  logic rst,
    output logic sclk_int,
    output logic rise,
    output logic fall
);

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          match;

    assign match = (cnt == CW'(SCLK_DIV - 1));

    // Half-period counter, wraps after SCLK_DIV cycles.
    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge c or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (match) cnt <= '0;
        else            cnt <= cnt + CW'(1);
    end

    // Internal SCLK level toggles at the end of every half period.
    always_ff @(posedge c or posedge rst) begin
        if (rst)        sclk_int <= 1'b0;
        else if (match) sclk_int <= ~sclk_int;
    end

    // Strobes mark the cycle in which sclk_int is about to change.
    assign rise = match & ~sclk_int;
    assign fall = match &  sclk_int;

endmodule

// File: rtl/spi_master_core.sv
// Single-channel SPI master: MSB-first shift out on mosi, shift in from miso,
// received word on rxd and a sticky done flag.
module spi_master_core
    import spi_master_core_pkg::*;
#(
    parameter int SCLK_DIV             = 8,
    parameter int W                    = 8,
    parameter int CPOL                 = 1,
    parameter int CPHA                 = 1,
    parameter int SAMPLE_OPPOSITE_EDGE = 0
) (
    input  logic         c,
    input  logic         rst,
    input  logic         start,
    output logic         done,
    input  logic [W-1:0] txd,
    output logic [W-1:0] rxd,
    input  logic         hold_cs,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso,
    output logic         cs
);

    localparam logic IDLE_LVL = (CPOL != 0);

    logic                 sclk_int, rise, fall;
    logic                 tx_edge, inactive_edge, rx_edge;
    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [W-1:0]         tx_shreg, rx_shreg;
    logic                 last_bit, exit_txrx, active;

    spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
        .c        (c),
        .rst      (rst),
        .sclk_int (sclk_int),
        .rise     (rise),
        .fall     (fall)
    );

    // Modes (1,1) and (0,0) share one internal edge map: data launches on the
    // fall strobe, the opposite strobe is the rise; CPOL only sets the idle level.
    if (CPOL != 0 && CPHA != 0) begin : g_mode11
        assign tx_edge       = fall;
        assign inactive_edge = rise;
    end else begin : g_mode00
        assign tx_edge       = fall;
        assign inactive_edge = rise;
    end

    assign rx_edge   = (SAMPLE_OPPOSITE_EDGE != 0) ? tx_edge : inactive_edge;
    assign last_bit  = (bit_cnt == BIT_CNT_W'(W));
    assign exit_txrx = (state_q == ST_TXRX) && tx_edge && last_bit;

    // State register.
    always_ff @(posedge c or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)         state_d = ST_SYNC;
            ST_SYNC: if (inactive_edge) state_d = ST_PRE;
            ST_PRE:  if (tx_edge)       state_d = ST_TXRX;
            ST_TXRX: if (exit_txrx)     state_d = ST_POST;
            ST_POST: if (tx_edge)       state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Bit counter: cleared before the word, counts sample-side edges during it.
    always_ff @(posedge c or posedge rst) begin
        if (rst)                                         bit_cnt <= '0;
        else if (state_q == ST_PRE)                      bit_cnt <= '0;
        else if (state_q == ST_TXRX && inactive_edge)    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end

    // Transmit shifter: tracks txd while idle, shifts left on each launch edge.
    always_ff @(posedge c or posedge rst) begin
        if (rst)                                   tx_shreg <= '0;
        else if (state_q == ST_IDLE)               tx_shreg <= txd;
        else if (state_q == ST_TXRX && tx_edge)    tx_shreg <= {tx_shreg[W-2:0], 1'b0};
    end

    // Receive shifter: cleared while idle, shifts miso in on each sample edge.
    always_ff @(posedge c or posedge rst) begin
        if (rst)                                   rx_shreg <= '0;
        else if (state_q == ST_IDLE)               rx_shreg <= '0;
        else if (state_q == ST_TXRX && rx_edge)    rx_shreg <= {rx_shreg[W-2:0], miso};
    end

    // Received word is captured once per frame and held until the next one.
    always_ff @(posedge c or posedge rst) begin
        if (rst)                     rxd <= '0;
        else if (state_q == ST_DONE) rxd <= rx_shreg;
    end

    // Sticky completion flag; a new start clears it and wins over the set.
    always_ff @(posedge c or posedge rst) begin
        if (rst)                     done <= 1'b0;
        else if (start)              done <= 1'b0;
        else if (state_q == ST_DONE) done <= 1'b1;
    end

    assign active = (state_q != ST_IDLE) | start;
    assign cs     = ~(hold_cs | active);
    assign sclk   = ((state_q == ST_TXRX) && !exit_txrx) ? sclk_int : IDLE_LVL;
    assign mosi   = ~cs & tx_shreg[W-1];

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core: two instances (mode (1,1) default sampling,
// mode (0,0) opposite-edge sampling) talking to behavioural SPI slaves.
module tb_spi_master_core;

    localparam int A_W   = 8;
    localparam int A_DIV = 50;
    localparam int B_W   = 26;
    localparam int B_DIV = 4;

    logic c = 1'b0;
    logic rst;
    always #5 c = ~c;

    logic           start_a, done_a, hold_a, sclk_a, mosi_a, miso_a, cs_a;
    logic [A_W-1:0] txd_a, rxd_a;
    logic           start_b, done_b, hold_b, sclk_b, mosi_b, miso_b, cs_b;
    logic [B_W-1:0] txd_b, rxd_b;

    spi_master_core #(.SCLK_DIV(A_DIV), .W(A_W), .CPOL(1), .CPHA(1), .SAMPLE_OPPOSITE_EDGE(0)) dut_a (
        .c(c), .rst(rst), .start(start_a), .done(done_a), .txd(txd_a), .rxd(rxd_a),
        .hold_cs(hold_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs(cs_a)
    );

    spi_master_core #(.SCLK_DIV(B_DIV), .W(B_W), .CPOL(0), .CPHA(0), .SAMPLE_OPPOSITE_EDGE(1)) dut_b (
        .c(c), .rst(rst), .start(start_b), .done(done_b), .txd(txd_b), .rxd(rxd_b),
        .hold_cs(hold_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs(cs_b)
    );

    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave A: mode (1,1), drives on SCLK fall, samples on rise
    logic [A_W-1:0] sw_a;
    logic [A_W-1:0] cap_a;
    int             idx_a, pulses_a, cs_rise_a;

    initial begin : slave_miso_a
        miso_a = 1'b0;
        idx_a  = 0;
        forever begin
            @(negedge sclk_a or posedge start_a);
            if (start_a) idx_a = 0;
            else if (!cs_a && idx_a < A_W) begin
                #1 miso_a = sw_a[A_W-1-idx_a];
                idx_a++;
            end
        end
    end

    initial begin : slave_cap_a
        cap_a    = '0;
        pulses_a = 0;
        forever begin
            @(posedge sclk_a or posedge start_a);
            if (start_a) begin
                cap_a    = '0;
                pulses_a = 0;
            end else if (!cs_a) begin
                cap_a = {cap_a[A_W-2:0], mosi_a};
                pulses_a++;
            end
        end
    end

    initial begin : cs_rise_cnt_a
        cs_rise_a = 0;
        forever begin
            @(posedge cs_a);
            cs_rise_a++;
        end
    end

    // ---------------- slave B: mode (0,0), master samples on fall, slave drives on rise
    logic [B_W-1:0] sw_b;
    logic [B_W-1:0] cap_b;
    int             idx_b, pulses_b;

    initial begin : slave_b
        miso_b   = 1'b0;
        idx_b    = 0;
        cap_b    = '0;
        pulses_b = 0;
        forever begin
            @(posedge sclk_b or posedge start_b);
            if (start_b) begin
                idx_b    = 0;
                cap_b    = '0;
                pulses_b = 0;
            end else if (!cs_b) begin
                cap_b = {cap_b[B_W-2:0], mosi_b};
                pulses_b++;
                if (idx_b < B_W) begin
                    #1 miso_b = sw_b[B_W-1-idx_b];
                    idx_b++;
                end
            end
        end
    end

    // ---------------- monitors: pop expected frame whenever done rises
    exp_t e_a, e_b;

    initial begin : mon_a
        forever begin
            @(posedge done_a);
            @(negedge c);
            if (q_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_unexpected_done: got done=1 expected no frame pending");
            end else begin
                e_a = q_a.pop_front();
                check("a_rxd",    32'(rxd_a),    e_a.rx);
                check("a_mosi",   32'(cap_a),    e_a.tx);
                check("a_pulses", 32'(pulses_a), 32'(A_W));
                check("a_cs_end", 32'(cs_a),     32'(!hold_a));
            end
        end
    end

    initial begin : mon_b
        forever begin
            @(posedge done_b);
            @(negedge c);
            if (q_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected_done: got done=1 expected no frame pending");
            end else begin
                e_b = q_b.pop_front();
                check("b_rxd",    32'(rxd_b),    e_b.rx);
                check("b_mosi",   32'(cap_b),    e_b.tx);
                check("b_pulses", 32'(pulses_b), 32'(B_W));
                check("b_cs_end", 32'(cs_b),     32'(!hold_b));
            end
        end
    end

    // ---------------- drivers
    task automatic xfer_a(input logic [A_W-1:0] tx, input logic [A_W-1:0] rx);
        int i;
        @(negedge c);
        txd_a = tx;
        sw_a  = rx;
        q_a.push_back('{tx: 32'(tx), rx: 32'(rx)});
        start_a = 1'b1;
        @(negedge c);
        start_a = 1'b0;
        check("a_done_clr", 32'(done_a), 32'd0);
        i = 0;
        while (!done_a && i < 3000) begin
            @(negedge c);
            i++;
        end
        if (!done_a) begin
            n_cmp++;
            n_fail++;
            $display("FAIL a_timeout: got done=0 expected done=1 within 3000 cycles");
        end
        @(negedge c);
    endtask

    task automatic xfer_b(input logic [B_W-1:0] tx, input logic [B_W-1:0] rx);
        int i;
        @(negedge c);
        txd_b = tx;
        sw_b  = rx;
        q_b.push_back('{tx: 32'(tx), rx: 32'(rx)});
        start_b = 1'b1;
        @(negedge c);
        start_b = 1'b0;
        check("b_done_clr", 32'(done_b), 32'd0);
        i = 0;
        while (!done_b && i < 1500) begin
            @(negedge c);
            i++;
        end
        if (!done_b) begin
            n_cmp++;
            n_fail++;
            $display("FAIL b_timeout: got done=0 expected done=1 within 1500 cycles");
        end
        @(negedge c);
    endtask

    // Starts a frame on A and hits reset part-way through the word.
    task automatic abort_a(input logic [A_W-1:0] tx, input int cycles);
        exp_t dropped;
        @(negedge c);
        txd_a = tx;
        sw_a  = '0;
        q_a.push_back('{tx: 32'(tx), rx: 32'd0});
        start_a = 1'b1;
        @(negedge c);
        start_a = 1'b0;
        repeat (cycles) @(negedge c);
        rst = 1'b1;
        #1;
        check("rst_mid_sclk", 32'(sclk_a), 32'd1);
        check("rst_mid_cs",   32'(cs_a),   32'd1);
        check("rst_mid_done", 32'(done_a), 32'd0);
        check("rst_mid_rxd",  32'(rxd_a),  32'd0);
        check("rst_mid_rxdb", 32'(rxd_b),  32'd0);
        dropped = q_a.pop_back();
        @(negedge c);
        rst = 1'b0;
    endtask

    // ---------------- main sequence
    int rises0;

    initial begin : main
        rst     = 1'b1;
        start_a = 1'b0; hold_a = 1'b0; txd_a = '0; sw_a = '0;
        start_b = 1'b0; hold_b = 1'b0; txd_b = '0; sw_b = '0;
        repeat (3) @(negedge c);
        rst = 1'b0;
        @(negedge c);

        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_rxd_a",  32'(rxd_a),  32'd0);
        check("rst_cs_a",   32'(cs_a),   32'd1);
        check("rst_sclk_a", 32'(sclk_a), 32'd1);
        check("rst_mosi_a", 32'(mosi_a), 32'd0);
        check("rst_done_b", 32'(done_b), 32'd0);
        check("rst_rxd_b",  32'(rxd_b),  32'd0);
        check("rst_cs_b",   32'(cs_b),   32'd1);
        check("rst_sclk_b", 32'(sclk_b), 32'd0);

        // Basic word with constant-high miso, then a patterned miso word.
        xfer_a(8'hA5, 8'hFF);
        xfer_a(8'h5A, 8'h3C);

        // hold_cs forces cs low in idle and lets txd's MSB through to mosi.
        hold_a = 1'b1;
        txd_a  = 8'h80;
        @(negedge c);
        check("hold_cs_idle", 32'(cs_a),   32'd0);
        check("hold_mosi_1",  32'(mosi_a), 32'd1);
        txd_a = 8'h00;
        @(negedge c);
        check("hold_mosi_0",  32'(mosi_a), 32'd0);

        // Two back-to-back words inside one held frame.
        rises0 = cs_rise_a;
        xfer_a(8'hA5, 8'($urandom()));
        xfer_a(8'h42, 8'($urandom()));
        check("hold_cs_rises", 32'(cs_rise_a - rises0), 32'd0);
        hold_a = 1'b0;
        @(negedge c);
        check("hold_release", 32'(cs_a), 32'd1);

        // Reset mid-word, then a clean word afterwards.
        abort_a(8'hC3, 400);
        xfer_a(8'hC3, 8'h99);

        for (int k = 0; k < 6; k++) xfer_a(8'($urandom()), 8'($urandom()));

        // Wide word, mode (0,0), opposite-edge sampling.
        xfer_b(26'h1514271, 26'h3FFFFFF);
        xfer_b(26'($urandom()), 26'h000003C);
        for (int k = 0; k < 8; k++) xfer_b(26'($urandom()), 26'($urandom()));

        repeat (4) @(negedge c);
        check("q_a_empty", 32'(q_a.size()), 32'd0);
        check("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
